// File: rtl/det_nms_3x3_if.sv
// Stream interfaces around the 3x3 determinant non-maximum suppressor:
// det_in_if carries the raster det stream in, pt_out_if carries keypoints out.

interface det_in_if #(
  parameter int DATA_WIDTH = 32
);
  logic signed [DATA_WIDTH-1:0] det_d;
  logic                         det_d_valid;

  modport master (output det_d, output det_d_valid);
  modport slave  (input  det_d, input  det_d_valid);
endinterface

interface pt_out_if #(
  parameter int DATA_WIDTH = 32,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
);
  logic                         pt_valid;
  logic [COL_W-1:0]             pt_x;
  logic [ROW_W-1:0]             pt_y;
  logic signed [DATA_WIDTH-1:0] pt_det;
  logic                         frame_done;

  modport master (output pt_valid, output pt_x, output pt_y, output pt_det, output frame_done);
  modport slave  (input  pt_valid, input  pt_x, input  pt_y, input  pt_det, input  frame_done);
endinterface

// File: rtl/det_nms_3x3.sv
// 3x3 non-maximum suppression on a raster stream of Hessian determinants.
// Two line buffers feed a 3x3 window; an interior centre is reported when it
// exceeds the threshold and is strictly greater than all eight neighbours.
// Pipeline: edge N samples pixel (c,r), N+1 evaluates, N+2 presents results.

module det_nms_3x3 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  det_in_if.slave                      din,
  input  logic signed [DATA_WIDTH-1:0] thresh,
  pt_out_if.master                     pt
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_wrap;
  logic             frame_end;
  logic             win_ready;

  assign col_wrap  = (col == COL_LAST);
  assign frame_end = col_wrap && (row == ROW_LAST);
  assign win_ready = (col >= COL_W'(2)) && (row >= ROW_W'(2));

  // Raster position of the pixel being accepted this cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (din.det_d_valid) begin
      if (col_wrap) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // lb0 holds row r-1, lb1 holds row r-2; win[row][col], row 2 = current line,
  // col 2 = newest column, so win[1][1] is the centre (c-1, r-1).
  logic signed [DATA_WIDTH-1:0] lb0 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic signed [DATA_WIDTH-1:0] win [3][3];

  // Line-buffer rotation (read-before-write) and window column shift.
  // NOTE: storage is deliberately not reset; stale contents are never used
  // because window validity is gated by the reset position counters.
  always_ff @(posedge clk) begin
    if (din.det_d_valid) begin
      lb0[col] <= din.det_d;
      lb1[col] <= lb0[col];
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[2][2] <= din.det_d;
      win[1][2] <= lb0[col];
      win[0][2] <= lb1[col];
    end
  end

  logic                         s1_valid;
  logic                         s1_last;
  logic [COL_W-1:0]             s1_x;
  logic [ROW_W-1:0]             s1_y;
  logic signed [DATA_WIDTH-1:0] thresh_q;

  // Stage 1: qualify the window just completed; strobes self-clear so the
  // pipeline drains at fixed latency even when input stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      thresh_q <= '0;
    end else begin
      s1_valid <= din.det_d_valid && win_ready;
      s1_last  <= din.det_d_valid && frame_end;
      if (din.det_d_valid) begin
        s1_x     <= col - 1'b1;
        s1_y     <= row - 1'b1;
        thresh_q <= thresh;
      end
    end
  end

  logic peak;

  // Strict local-maximum test of the centre against threshold and neighbours.
  // NOTE: the result is assigned a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    peak = (win[1][1] > thresh_q);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(i == 1 && j == 1) && !(win[1][1] > win[i][j])) peak = 1'b0;
      end
    end
  end

  logic                         s2_hit;
  logic                         s2_last;
  logic [COL_W-1:0]             s2_x;
  logic [ROW_W-1:0]             s2_y;
  logic signed [DATA_WIDTH-1:0] s2_det;

  // Stage 2: register the detection decision with its coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_hit  <= 1'b0;
      s2_last <= 1'b0;
      s2_x    <= '0;
      s2_y    <= '0;
      s2_det  <= '0;
    end else begin
      s2_hit  <= s1_valid && peak;
      s2_last <= s1_last;
      if (s1_valid) begin
        s2_x   <= s1_x;
        s2_y   <= s1_y;
        s2_det <= win[1][1];
      end
    end
  end

  // Output stage: strobes for one cycle, keypoint fields hold between hits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt.pt_valid   <= 1'b0;
      pt.pt_x       <= '0;
      pt.pt_y       <= '0;
      pt.pt_det     <= '0;
      pt.frame_done <= 1'b0;
    end else begin
      pt.pt_valid   <= s2_hit;
      pt.frame_done <= s2_last;
      if (s2_hit) begin
        pt.pt_x   <= s2_x;
        pt.pt_y   <= s2_y;
        pt.pt_det <= s2_det;
      end
    end
  end

endmodule
